// File: rtl/nn_neuron_mac_if.sv
`default_nettype none
// ============================================================================
// Module   : nn_neuron_mac_if
// Purpose  : Control, weight-write, sample and result bundle for nn_neuron_mac.
// Revision : 1.0 - initial release
// ============================================================================
interface nn_neuron_mac_if #(
    parameter int N_IN = 4,
    parameter int XW   = 4,
    parameter int BW   = 8,
    parameter int OUTW = 8
);
    logic                          ena;
    logic                          clr;
    logic                          w_we;
    logic [$clog2(N_IN + 1)-1:0]   w_addr;
    logic [BW-1:0]                 w_data;
    logic                          x_valid;
    logic                          x_ready;
    logic [XW-1:0]                 x_data;
    logic                          out_valid;
    logic [OUTW-1:0]               out_data;
    logic                          busy;

    modport master (
        output ena, clr, w_we, w_addr, w_data, x_valid, x_data,
        input  x_ready, out_valid, out_data, busy
    );

    modport slave (
        input  ena, clr, w_we, w_addr, w_data, x_valid, x_data,
        output x_ready, out_valid, out_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/nn_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module   : nn_neuron_mac
// Purpose  : Single-neuron multiply-accumulate with bias, ReLU and saturation.
// Revision : 1.0 - initial release
// ============================================================================
module nn_neuron_mac #(
    parameter int N_IN = 4,
    parameter int XW   = 4,
    parameter int WW   = 4,
    parameter int BW   = 8,
    parameter int ACCW = 12,
    parameter int OUTW = 8
) (
    input  wire             clk,
    input  wire             rst_n,
    nn_neuron_mac_if.slave  bus
);
    localparam int c_IW = $clog2(N_IN);
    localparam int c_AW = $clog2(N_IN + 1);
    localparam int c_PW = XW + WW;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ACC  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [c_IW-1:0]        c_LAST    = c_IW'(N_IN - 1);
    localparam logic signed [ACCW-1:0] c_OUT_MAX = ACCW'({OUTW{1'b1}});

    logic [1:0]              r_state;
    logic signed [ACCW-1:0]  r_acc;
    logic [c_IW-1:0]         r_idx;
    logic signed [WW-1:0]    r_w [N_IN];
    logic signed [BW-1:0]    r_bias;
    logic [OUTW-1:0]         r_out_data;

    logic                    w_active;
    logic                    w_accept;
    logic                    w_wr_en;
    logic signed [c_PW-1:0]  w_x_ext;
    logic signed [c_PW-1:0]  w_w_ext;
    logic signed [c_PW-1:0]  w_prod;
    logic signed [ACCW-1:0]  w_prod_ext;
    logic signed [ACCW-1:0]  w_bias_ext;
    logic [OUTW-1:0]         w_sat;

    assign w_active      = bus.ena && !bus.clr;
    assign bus.x_ready   = rst_n && bus.ena && ((r_state == c_IDLE) || (r_state == c_ACC));
    assign bus.busy      = (r_state == c_ACC);
    assign bus.out_valid = w_active && (r_state == c_DONE);
    // The strobe cycle shows the fresh result; afterwards the register holds it.
    assign bus.out_data  = bus.out_valid ? w_sat : r_out_data;
    assign w_accept      = bus.x_valid && bus.x_ready && !bus.clr;
    assign w_wr_en       = w_active && bus.w_we && (r_state == c_IDLE);

    // r_idx is 0 whenever the FSM is idle, so this also serves the first sample.
    assign w_x_ext    = {{WW{bus.x_data[XW-1]}}, bus.x_data};
    assign w_w_ext    = {{XW{r_w[r_idx][WW-1]}}, r_w[r_idx]};
    assign w_prod     = w_x_ext * w_w_ext;
    assign w_prod_ext = {{(ACCW - c_PW){w_prod[c_PW-1]}}, w_prod};
    assign w_bias_ext = {{(ACCW - BW){r_bias[BW-1]}}, r_bias};

    always_comb begin
        w_sat = r_acc[OUTW-1:0];
        if (r_acc[ACCW-1]) begin
            w_sat = '0;
        end else if (r_acc > c_OUT_MAX) begin
            w_sat = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) begin
                r_w[i] <= '0;
            end
            r_bias <= '0;
        end else if (w_wr_en) begin
            for (int i = 0; i < N_IN; i++) begin
                if (bus.w_addr == c_AW'(i)) begin
                    r_w[i] <= bus.w_data[WW-1:0];
                end
            end
            if (bus.w_addr == c_AW'(N_IN)) begin
                r_bias <= bus.w_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_acc      <= '0;
            r_idx      <= '0;
            r_out_data <= '0;
        end else if (bus.ena) begin
            if (bus.clr) begin
                r_state <= c_IDLE;
                r_acc   <= '0;
                r_idx   <= '0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (w_accept) begin
                            r_acc   <= w_bias_ext + w_prod_ext;
                            r_idx   <= c_IW'(1);
                            r_state <= c_ACC;
                        end
                    end
                    c_ACC: begin
                        if (w_accept) begin
                            r_acc <= r_acc + w_prod_ext;
                            if (r_idx == c_LAST) begin
                                r_idx   <= '0;
                                r_state <= c_DONE;
                            end else begin
                                r_idx <= r_idx + c_IW'(1);
                            end
                        end
                    end
                    c_DONE: begin
                        r_out_data <= w_sat;
                        r_state    <= c_IDLE;
                    end
                    default: begin
                        r_state <= c_IDLE;
                        r_idx   <= '0;
                    end
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_nn_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_neuron_mac
// Purpose  : Self-checking bench for nn_neuron_mac against an integer model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nn_neuron_mac;
    localparam int N_IN = 4;
    localparam int XW   = 4;
    localparam int WW   = 4;
    localparam int BW   = 8;
    localparam int ACCW = 12;
    localparam int OUTW = 8;
    localparam int AW   = $clog2(N_IN + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nn_neuron_mac_if #(.N_IN(N_IN), .XW(XW), .BW(BW), .OUTW(OUTW)) bus ();

    nn_neuron_mac #(
        .N_IN(N_IN), .XW(XW), .WW(WW), .BW(BW), .ACCW(ACCW), .OUTW(OUTW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int m_w [N_IN];
    int m_bias;

    function automatic int sext_w(input int d);
        logic signed [WW-1:0] t;
        t = d[WW-1:0];
        return int'(t);
    endfunction

    function automatic int sext_b(input int d);
        logic signed [BW-1:0] t;
        t = d[BW-1:0];
        return int'(t);
    endfunction

    // Reference: dot product plus bias in plain integers, then ReLU and clamp.
    function automatic int model(input int xs [N_IN]);
        int s;
        s = m_bias;
        for (int i = 0; i < N_IN; i++) s += xs[i] * m_w[i];
        if (s < 0) return 0;
        if (s > (1 << OUTW) - 1) return (1 << OUTW) - 1;
        return s;
    endfunction

    task automatic write_reg(input int addr, input int data, input bit taken);
        bus.w_we   = 1'b1;
        bus.w_addr = AW'(addr);
        bus.w_data = BW'(data);
        @(negedge clk);
        bus.w_we = 1'b0;
        if (taken) begin
            if (addr < N_IN) m_w[addr] = sext_w(data);
            else if (addr == N_IN) m_bias = sext_b(data);
        end
    endtask

    task automatic load_all(input int w [N_IN], input int b);
        for (int i = 0; i < N_IN; i++) write_reg(i, w[i], 1'b1);
        write_reg(N_IN, b, 1'b1);
    endtask

    task automatic feed_partial(input int xs [N_IN], input int n);
        for (int i = 0; i < n; i++) begin
            bus.x_valid = 1'b1;
            bus.x_data  = XW'(xs[i]);
            @(negedge clk);
        end
        bus.x_valid = 1'b0;
    endtask

    // Streams one vector; reports the strobed result, strobe count, whether the
    // strobe came in the cycle after the last accept, and the accept span.
    task automatic run_vector(input int xs [N_IN], input int gap_pct, input bit pause,
                              input int wr_k, input int wr_addr, input int wr_data,
                              output int res, output int nstrobe, output bit lat_err,
                              output int span);
        int  k, iter, first_it, last_it, strobe_it, paused;
        bit  acc_now, wr_done;
        k = 0; iter = 0; first_it = -1; last_it = -1; strobe_it = -2;
        paused = 0; wr_done = 1'b0; nstrobe = 0; res = -1;
        while (iter < 300 && (k < N_IN || iter <= last_it + 2)) begin
            bus.ena  = 1'b1;
            bus.w_we = 1'b0;
            if (pause && k == 2 && paused < 3) begin
                bus.ena = 1'b0;
                paused++;
            end
            if (k < N_IN && (gap_pct == 0 || $urandom_range(0, 99) >= gap_pct)) begin
                bus.x_valid = 1'b1;
                bus.x_data  = XW'(xs[k]);
            end else begin
                bus.x_valid = 1'b0;
                bus.x_data  = XW'($urandom);
            end
            if (!wr_done && wr_k == k && bus.x_valid && bus.ena) begin
                bus.w_we   = 1'b1;
                bus.w_addr = AW'(wr_addr);
                bus.w_data = BW'(wr_data);
                wr_done    = 1'b1;
            end
            #1;
            if (!bus.ena) begin
                checks++;
                if (bus.x_ready !== 1'b0)
                    begin failures++; $display("FAIL x_ready_ena_low: got %b want 0", bus.x_ready); end
            end
            acc_now = bus.x_valid && bus.x_ready;
            @(negedge clk);
            if (acc_now) begin
                if (k == 0) first_it = iter;
                k++;
                if (k == N_IN) last_it = iter;
            end
            if (bus.out_valid === 1'b1) begin
                nstrobe++;
                res = int'(bus.out_data);
                strobe_it = iter;
            end
            iter++;
        end
        bus.x_valid = 1'b0;
        bus.w_we    = 1'b0;
        bus.ena     = 1'b1;
        checks++;
        if (k < N_IN) begin
            failures++;
            $display("FAIL vector_timeout: accepted %0d samples want %0d", k, N_IN);
        end
        lat_err = (strobe_it != last_it);
        span    = last_it - first_it + 1;
    endtask

    task automatic check_vec(input string name, input int xs [N_IN], input int gap_pct,
                             input bit pause);
        int res, ns, span, exp;
        bit le;
        exp = model(xs);
        run_vector(xs, gap_pct, pause, -1, 0, 0, res, ns, le, span);
        checks++;
        if (res !== exp || ns !== 1 || le)
            begin failures++; $display("FAIL %s: got %0d strobes=%0d late=%0b want %0d strobes=1", name, res, ns, le, exp); end
    endtask

    task automatic test_reset();
        bus.ena = 1'b1; bus.clr = 1'b0; bus.w_we = 1'b0; bus.w_addr = '0;
        bus.w_data = '0; bus.x_valid = 1'b0; bus.x_data = '0;
        rst_n = 1'b0;
        for (int i = 0; i < N_IN; i++) m_w[i] = 0;
        m_bias = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.x_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.busy !== 1'b0)
            begin failures++; $display("FAIL reset_outputs: got rdy=%b vld=%b data=%0d busy=%b want 0 0 0 0",
                bus.x_ready, bus.out_valid, bus.out_data, bus.busy); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.x_ready !== 1'b1)
            begin failures++; $display("FAIL idle_ready: got %b want 1", bus.x_ready); end
    endtask

    task automatic test_basic();
        int w [N_IN] = '{1, 2, -1, 3};
        int v [N_IN] = '{2, 3, 4, 1};
        int res, ns, span;
        bit le;
        load_all(w, 0);
        run_vector(v, 0, 1'b0, -1, 0, 0, res, ns, le, span);
        checks++;
        if (res !== 7 || ns !== 1 || le)
            begin failures++; $display("FAIL basic_result: got %0d strobes=%0d late=%0b want 7 strobes=1", res, ns, le); end
        checks++;
        if (span !== N_IN)
            begin failures++; $display("FAIL back_to_back_span: got %0d want %0d", span, N_IN); end
        checks++;
        if (bus.out_data !== 8'd7 || bus.out_valid !== 1'b0)
            begin failures++; $display("FAIL result_hold: got %0d vld=%b want 7 vld=0", bus.out_data, bus.out_valid); end
    endtask

    task automatic test_saturate_relu();
        int w [N_IN] = '{7, 7, 7, 7};
        int vp [N_IN] = '{7, 7, 7, 7};
        int vn [N_IN] = '{-8, -8, -8, -8};
        load_all(w, 127);
        check_vec("saturate_255", vp, 0, 1'b0);
        write_reg(N_IN, -128, 1'b1);
        check_vec("relu_zero", vn, 0, 1'b0);
    endtask

    task automatic test_gaps_ena();
        int w [N_IN] = '{1, 2, -1, 3};
        int v [N_IN] = '{2, 3, 4, 1};
        load_all(w, 0);
        check_vec("gaps_and_ena_pause", v, 40, 1'b1);
        bus.ena = 1'b0;
        write_reg(0, 5, 1'b0);
        bus.ena = 1'b1;
        check_vec("write_with_ena_low", v, 0, 1'b0);
    endtask

    task automatic test_write_rules();
        int v [N_IN] = '{2, 3, 4, 1};
        int res, ns, span;
        bit le;
        run_vector(v, 0, 1'b0, 2, 0, 5, res, ns, le, span);
        checks++;
        if (res !== 7 || ns !== 1)
            begin failures++; $display("FAIL write_in_acc: got %0d strobes=%0d want 7", res, ns); end
        check_vec("write_in_acc_ignored", v, 0, 1'b0);
        // Write and first accept together: this vector uses the old w[0].
        run_vector(v, 0, 1'b0, 0, 0, 2, res, ns, le, span);
        checks++;
        if (res !== 7 || ns !== 1)
            begin failures++; $display("FAIL write_collision_old: got %0d strobes=%0d want 7", res, ns); end
        m_w[0] = 2;
        check_vec("write_collision_new", v, 0, 1'b0);
        write_reg(0, 1, 1'b1);
        write_reg(N_IN + 2, 100, 1'b1);
        check_vec("addr_out_of_range", v, 0, 1'b0);
    endtask

    task automatic test_clr();
        int v [N_IN] = '{2, 3, 4, 1};
        feed_partial(v, 2);
        checks++;
        if (bus.busy !== 1'b1)
            begin failures++; $display("FAIL busy_mid_vector: got %b want 1", bus.busy); end
        bus.clr = 1'b1; bus.x_valid = 1'b1; bus.x_data = XW'(7);
        @(negedge clk);
        bus.clr = 1'b0; bus.x_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'd7)
            begin failures++; $display("FAIL clr_abort: got busy=%b vld=%b data=%0d want 0 0 7",
                bus.busy, bus.out_valid, bus.out_data); end
        check_vec("after_clr", v, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int w [N_IN] = '{1, 2, -1, 3};
        int v [N_IN] = '{2, 3, 4, 1};
        feed_partial(v, 2);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_data !== '0 || bus.busy !== 1'b0 || bus.x_ready !== 1'b0 || bus.out_valid !== 1'b0)
            begin failures++; $display("FAIL reset_mid_vector: got data=%0d busy=%b rdy=%b vld=%b want 0 0 0 0",
                bus.out_data, bus.busy, bus.x_ready, bus.out_valid); end
        for (int i = 0; i < N_IN; i++) m_w[i] = 0;
        m_bias = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_vec("weights_cleared", v, 0, 1'b0);
        load_all(w, 0);
        check_vec("reload_after_reset", v, 0, 1'b0);
    endtask

    task automatic test_random();
        int v [N_IN];
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < N_IN; i++) write_reg(i, int'($urandom_range(0, 255)), 1'b1);
            write_reg(N_IN, int'($urandom_range(0, 255)), 1'b1);
            for (int i = 0; i < N_IN; i++) v[i] = int'($urandom_range(0, 15)) - 8;
            check_vec("random_vector", v, int'($urandom_range(0, 50)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_saturate_relu();
        test_gaps_ena();
        test_write_rules();
        test_clr();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
